// File: rtl/sram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_arbiter_pkg
// Shared definitions for the SRAM port arbiter: FSM state encoding and the
// requester identifiers used for gnt / last_gnt.
// ---------------------------------------------------------------------------
package sram_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Requester identifiers: 0 = data-side cache controller, 1 = instruction fetch.
  localparam logic REQ_D = 1'b0;
  localparam logic REQ_I = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if
// Bundles the two requester ports and the SRAM controller port of the arbiter.
//   d_*    : data-side requester (read/write), ready/read data back
//   i_*    : instruction-fetch requester (read only), ready/read data back
//   sram_* : single SRAM controller port
// Modports:
//   slave  : the arbiter's view (takes requests and SRAM responses)
//   master : the surrounding system's view (requesters plus SRAM controller)
// ---------------------------------------------------------------------------
interface sram_arbiter_if;

  logic [31:0] d_address;
  logic [31:0] d_write_data;
  logic        d_r_en;
  logic        d_w_en;
  logic [63:0] d_read_data;
  logic        d_ready;

  logic [31:0] i_address;
  logic        i_r_en;
  logic [63:0] i_read_data;
  logic        i_ready;

  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic        sram_write_en;
  logic        sram_read_en;
  logic [63:0] sram_read_data;
  logic        sram_ready;

  modport slave (
    input  d_address, d_write_data, d_r_en, d_w_en,
    input  i_address, i_r_en,
    input  sram_read_data, sram_ready,
    output d_read_data, d_ready, i_read_data, i_ready,
    output sram_address, sram_write_data, sram_write_en, sram_read_en
  );

  modport master (
    output d_address, d_write_data, d_r_en, d_w_en,
    output i_address, i_r_en,
    output sram_read_data, sram_ready,
    input  d_read_data, d_ready, i_read_data, i_ready,
    input  sram_address, sram_write_data, sram_write_en, sram_read_en
  );

endinterface

// File: rtl/sram_arbiter_arb_pick2.sv
// ---------------------------------------------------------------------------
// arb_pick2
// Combinational two-way picker.
//   req0, req1 : request terms of requester 0 (data) and 1 (instruction)
//   last_gnt   : requester granted most recently
//   winner     : selected requester (REQ_D / REQ_I), meaningful when valid
//   valid      : at least one request present
// FIXED_PRIO=1 lets requester 0 win every contention; otherwise the
// requester that was not granted last wins.
// ---------------------------------------------------------------------------
module arb_pick2
  import sram_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic winner,
  output logic valid
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    winner = REQ_D;
    valid  = req0 | req1;
    if (req0 && req1) begin
      winner = (FIXED_PRIO != 0) ? REQ_D : ~last_gnt;
    end else if (req1) begin
      winner = REQ_I;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Shares the single SRAM controller port between the data-side cache
// controller (requester 0, read/write) and the instruction-fetch path
// (requester 1, read only). The winning request is latched and held on the
// SRAM side until sram_ready; every transaction is followed by one IDLE
// turnaround cycle in which pending requests are re-arbitrated.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : sram_arbiter_if.slave (requesters + SRAM controller)
//   timeout_err : sticky flag, a transaction stalled WD_LIMIT busy cycles
// ---------------------------------------------------------------------------
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int WD_WIDTH   = 8,
  parameter int WD_LIMIT   = 200
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus,
  output logic          timeout_err
);

  localparam logic [WD_WIDTH-1:0] WD_LIMIT_V = WD_WIDTH'(WD_LIMIT);

  state_e              state;
  logic                gnt;
  logic                last_gnt;
  logic                op_wr;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [WD_WIDTH-1:0] wd_cnt;

  logic req0, req1;
  logic pick_winner, pick_valid;
  logic busy, done;

  // Both enables high from the data side counts as a write.
  assign req0 = bus.d_r_en | bus.d_w_en;
  assign req1 = bus.i_r_en;

  arb_pick2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .req0    (req0),
    .req1    (req1),
    .last_gnt(last_gnt),
    .winner  (pick_winner),
    .valid   (pick_valid)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state       <= ST_IDLE;
      gnt         <= REQ_D;
      last_gnt    <= REQ_I;  // requester 0 wins the first contention
      op_wr       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (wd_cnt == WD_LIMIT_V) timeout_err <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state    <= ST_BUSY;
            gnt      <= pick_winner;
            last_gnt <= pick_winner;
            wd_cnt   <= '0;
            if (pick_winner == REQ_D) begin
              op_wr   <= bus.d_w_en;
              addr_q  <= bus.d_address;
              wdata_q <= bus.d_write_data;
            end else begin
              op_wr   <= 1'b0;
              addr_q  <= bus.i_address;
              wdata_q <= '0;
            end
          end
        end
        ST_BUSY: begin
          if (bus.sram_ready) begin
            state <= ST_IDLE;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_BUSY);
  assign done = busy & bus.sram_ready;

  // SRAM side: driven from latched values only, zero outside BUSY.
  assign bus.sram_address    = busy ? addr_q : '0;
  assign bus.sram_write_en   = busy & op_wr;
  assign bus.sram_read_en    = busy & ~op_wr;
  assign bus.sram_write_data = (busy & op_wr) ? wdata_q : '0;

  // Ready is high for an idle requester and in its completion cycle only.
  assign bus.d_ready     = ~req0 | (done & (gnt == REQ_D));
  assign bus.i_ready     = ~req1 | (done & (gnt == REQ_I));
  assign bus.d_read_data = (done & (gnt == REQ_D)) ? bus.sram_read_data : '0;
  assign bus.i_read_data = (done & (gnt == REQ_I)) ? bus.sram_read_data : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
// Two arbiters (round-robin and fixed priority) driven by the same requester
// and SRAM stimulus. A transaction-level model of each is stepped every
// clock and compared against every DUT output on the falling edge; directed
// checks with literal values pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int WD_LIMIT = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d_address = '0;
  logic [31:0] d_write_data = '0;
  logic        d_r_en = 1'b0;
  logic        d_w_en = 1'b0;
  logic [31:0] i_address = '0;
  logic        i_r_en = 1'b0;
  logic [63:0] sram_read_data = '0;
  logic        sram_ready = 1'b0;
  logic        to_rr, to_fp;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_arbiter_if ifc_rr ();
  sram_arbiter_if ifc_fp ();

  assign ifc_rr.d_address      = d_address;
  assign ifc_rr.d_write_data   = d_write_data;
  assign ifc_rr.d_r_en         = d_r_en;
  assign ifc_rr.d_w_en         = d_w_en;
  assign ifc_rr.i_address      = i_address;
  assign ifc_rr.i_r_en         = i_r_en;
  assign ifc_rr.sram_read_data = sram_read_data;
  assign ifc_rr.sram_ready     = sram_ready;
  assign ifc_fp.d_address      = d_address;
  assign ifc_fp.d_write_data   = d_write_data;
  assign ifc_fp.d_r_en         = d_r_en;
  assign ifc_fp.d_w_en         = d_w_en;
  assign ifc_fp.i_address      = i_address;
  assign ifc_fp.i_r_en         = i_r_en;
  assign ifc_fp.sram_read_data = sram_read_data;
  assign ifc_fp.sram_ready     = sram_ready;

  sram_arbiter #(.FIXED_PRIO(0), .WD_WIDTH(8), .WD_LIMIT(WD_LIMIT)) u_rr (
    .clk(clk), .rst(rst), .bus(ifc_rr), .timeout_err(to_rr)
  );
  sram_arbiter #(.FIXED_PRIO(1), .WD_WIDTH(8), .WD_LIMIT(WD_LIMIT)) u_fp (
    .clk(clk), .rst(rst), .bus(ifc_fp), .timeout_err(to_fp)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // -------------------------------------------------------------------------
  // Transaction-level model: either idle, or owning one outstanding
  // transaction described by (owner, write?, address, data) plus the number
  // of cycles it has waited without a completion.
  // -------------------------------------------------------------------------
  typedef struct {
    bit          busy;
    bit          owner;  // 0 = data side, 1 = instruction side
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          last;
    int          stall;
    bit          err;
  } mdl_t;

  mdl_t m_rr, m_fp;
  bit   mdl_ok = 1'b0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.busy = 0; m.owner = 0; m.wr = 0; m.addr = '0; m.wdata = '0;
    m.last = 1; m.stall = 0; m.err = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input bit fixed_prio);
    mdl_t n;
    bit want_d, want_i, take_i;
    n = m;
    want_d = d_r_en | d_w_en;
    want_i = i_r_en;
    if (m.stall == WD_LIMIT) n.err = 1;
    if (!m.busy) begin
      if (want_d || want_i) begin
        if (want_d && want_i) take_i = fixed_prio ? 1'b0 : !m.last;
        else                  take_i = want_i;
        n.busy  = 1;
        n.owner = take_i;
        n.last  = take_i;
        n.wr    = !take_i && d_w_en;
        n.addr  = take_i ? i_address : d_address;
        n.wdata = take_i ? 32'd0 : d_write_data;
        n.stall = 0;
      end
    end else if (sram_ready) begin
      n.busy = 0;
    end else if (m.stall < 255) begin
      n.stall = m.stall + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m_rr   <= rst ? mdl_reset() : mdl_step(m_rr, 1'b0);
    m_fp   <= rst ? mdl_reset() : mdl_step(m_fp, 1'b1);
    mdl_ok <= mdl_ok | rst;
  end

  task automatic compare_dut(input string tag, input mdl_t m,
                             input logic [31:0] sa, input logic [31:0] sw,
                             input logic we, input logic re,
                             input logic [63:0] drd, input logic dr,
                             input logic [63:0] ird, input logic ir,
                             input logic to);
    bit d_done, i_done;
    d_done = m.busy && sram_ready && !m.owner;
    i_done = m.busy && sram_ready &&  m.owner;
    check({tag, ".sram_address"},    64'(sa), m.busy ? 64'(m.addr) : 64'd0);
    check({tag, ".sram_write_en"},   64'(we), 64'(m.busy && m.wr));
    check({tag, ".sram_read_en"},    64'(re), 64'(m.busy && !m.wr));
    check({tag, ".sram_write_data"}, 64'(sw), (m.busy && m.wr) ? 64'(m.wdata) : 64'd0);
    check({tag, ".d_ready"},     64'(dr), 64'(!(d_r_en || d_w_en) || d_done));
    check({tag, ".i_ready"},     64'(ir), 64'(!i_r_en || i_done));
    check({tag, ".d_read_data"}, drd, d_done ? sram_read_data : 64'd0);
    check({tag, ".i_read_data"}, ird, i_done ? sram_read_data : 64'd0);
    check({tag, ".timeout_err"}, 64'(to), 64'(m.err));
  endtask

  always @(negedge clk) begin
    if (mdl_ok) begin
      compare_dut("rr", m_rr, ifc_rr.sram_address, ifc_rr.sram_write_data,
                  ifc_rr.sram_write_en, ifc_rr.sram_read_en, ifc_rr.d_read_data,
                  ifc_rr.d_ready, ifc_rr.i_read_data, ifc_rr.i_ready, to_rr);
      compare_dut("fp", m_fp, ifc_fp.sram_address, ifc_fp.sram_write_data,
                  ifc_fp.sram_write_en, ifc_fp.sram_read_en, ifc_fp.d_read_data,
                  ifc_fp.d_ready, ifc_fp.i_read_data, ifc_fp.i_ready, to_fp);
    end
  end

  // Inputs change 2 time units after a rising edge; checks happen at the
  // following falling edge, within the same cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    // ---- reset ----
    tick(); tick(); rst = 1'b0;
    at_neg();
    check("reset.sram_address",  64'(ifc_rr.sram_address),  64'd0);
    check("reset.sram_read_en",  64'(ifc_rr.sram_read_en),  64'd0);
    check("reset.sram_write_en", 64'(ifc_rr.sram_write_en), 64'd0);
    check("reset.d_ready",       64'(ifc_rr.d_ready),       64'd1);
    check("reset.i_ready",       64'(ifc_rr.i_ready),       64'd1);
    check("reset.timeout_err",   64'(to_rr),                64'd0);

    // ---- D read alone, completion 5 cycles after the request ----
    tick(); d_address = 32'h0000_0410; d_r_en = 1'b1;
    at_neg();
    check("rd.c0_read_en", 64'(ifc_rr.sram_read_en), 64'd0);
    check("rd.c0_d_ready", 64'(ifc_rr.d_ready),      64'd0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c >= 3) sram_read_data = 64'h1122334455667788;
      if (c == 5) sram_ready = 1'b1;
      at_neg();
      check("rd.read_en",     64'(ifc_rr.sram_read_en), 64'd1);
      check("rd.address",     64'(ifc_rr.sram_address), 64'h410);
      check("rd.d_ready",     64'(ifc_rr.d_ready),      (c == 5) ? 64'd1 : 64'd0);
      check("rd.d_read_data", ifc_rr.d_read_data,       (c == 5) ? 64'h1122334455667788 : 64'd0);
      check("rd.i_ready",     64'(ifc_rr.i_ready),      64'd1);
    end
    tick(); d_r_en = 1'b0; sram_ready = 1'b0; sram_read_data = '0;
    at_neg();
    check("rd.turnaround_read_en", 64'(ifc_rr.sram_read_en), 64'd0);

    // ---- D write ----
    tick(); d_address = 32'h0000_0500; d_write_data = 32'hDEAD_BEEF; d_w_en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) sram_ready = 1'b1;
      at_neg();
      check("wr.write_en",   64'(ifc_rr.sram_write_en),   64'd1);
      check("wr.write_data", 64'(ifc_rr.sram_write_data), 64'hDEADBEEF);
      check("wr.read_en",    64'(ifc_rr.sram_read_en),    64'd0);
      check("wr.d_ready",    64'(ifc_rr.d_ready),         (c == 3) ? 64'd1 : 64'd0);
    end
    tick(); d_w_en = 1'b0; sram_ready = 1'b0;

    // ---- address change during BUSY is ignored ----
    tick(); d_address = 32'h0000_0600; d_r_en = 1'b1;
    tick(); d_address = 32'hFFFF_0000;
    at_neg();
    check("hold.address_c1", 64'(ifc_rr.sram_address), 64'h600);
    tick(); sram_ready = 1'b1;
    at_neg();
    check("hold.address_c2", 64'(ifc_rr.sram_address), 64'h600);
    tick(); d_r_en = 1'b0; sram_ready = 1'b0;

    // ---- contention from reset: RR alternates, FP always serves D ----
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    tick();
    d_address = 32'h0000_0D00; d_r_en = 1'b1;
    i_address = 32'h0000_1100; i_r_en = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick(); sram_ready = 1'b1;
      at_neg();
      check("rr.owner_addr", 64'(ifc_rr.sram_address), (t % 2 == 0) ? 64'hD00 : 64'h1100);
      check("rr.d_ready",    64'(ifc_rr.d_ready),      (t % 2 == 0) ? 64'd1 : 64'd0);
      check("rr.i_ready",    64'(ifc_rr.i_ready),      (t % 2 == 1) ? 64'd1 : 64'd0);
      check("fp.owner_addr", 64'(ifc_fp.sram_address), 64'hD00);
      check("fp.i_ready",    64'(ifc_fp.i_ready),      64'd0);
      tick(); sram_ready = 1'b0;
      if (t == 3) begin d_r_en = 1'b0; i_r_en = 1'b0; end
      at_neg();
      check("rr.turnaround_read_en", 64'(ifc_rr.sram_read_en), 64'd0);
      if (t < 3) check("rr.turnaround_i_ready", 64'(ifc_rr.i_ready), 64'd0);
    end

    // ---- reset in the middle of a D transaction ----
    tick(); d_address = 32'h0000_0800; d_r_en = 1'b1;
    tick();
    at_neg();
    check("rst.busy_read_en", 64'(ifc_rr.sram_read_en), 64'd1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; d_r_en = 1'b0;
    at_neg();
    check("rst.sram_address",  64'(ifc_rr.sram_address),  64'd0);
    check("rst.sram_read_en",  64'(ifc_rr.sram_read_en),  64'd0);
    check("rst.sram_write_en", 64'(ifc_rr.sram_write_en), 64'd0);
    check("rst.timeout_err",   64'(to_rr),                64'd0);
    tick();
    d_address = 32'h0000_0900; d_r_en = 1'b1;
    i_address = 32'h0000_0A00; i_r_en = 1'b1;
    tick();
    at_neg();
    check("rst.first_contention_addr", 64'(ifc_rr.sram_address), 64'h900);
    tick(); sram_ready = 1'b1;
    tick(); sram_ready = 1'b0; d_r_en = 1'b0; i_r_en = 1'b0;

    // ---- watchdog: I read stalled for 210 cycles ----
    tick(); i_address = 32'h0000_0700; i_r_en = 1'b1;
    for (int c = 1; c <= 211; c++) begin
      tick();
      if (c == 211) sram_ready = 1'b1;
      at_neg();
      if (c == 200) check("wd.not_yet", 64'(to_rr), 64'd0);
      if (c == 205) begin
        check("wd.raised_rr", 64'(to_rr), 64'd1);
        check("wd.raised_fp", 64'(to_fp), 64'd1);
      end
      if (c == 211) check("wd.late_ready", 64'(ifc_rr.i_ready), 64'd1);
    end
    tick(); sram_ready = 1'b0; i_r_en = 1'b0;
    at_neg();
    check("wd.sticky",       64'(to_rr),               64'd1);
    check("wd.idle_read_en", 64'(ifc_rr.sram_read_en), 64'd0);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    at_neg();
    check("wd.cleared_by_rst", 64'(to_rr), 64'd0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
